// File: rtl/flit_fifo_pkg.sv
// Default sizing for the flit FIFO: one NoC flit per word, eight-deep buffer.
package flit_fifo_pkg;
  localparam int FIFO_SLOTS = 8;
  localparam int FIFO_WIDTH = 34;
endpackage

// File: rtl/flit_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and a
// per-cycle protocol-error flag (push into full, or pop from empty).
module flit_fifo
  import flit_fifo_pkg::*;
#(
  parameter int SLOTS = FIFO_SLOTS,
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             error_o,
  output logic             full_o,
  output logic             empty_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(SLOTS) + 1;
  localparam int IW = PW - 1;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

  // A push into a full FIFO still succeeds when a pop frees the head slot
  // in the same cycle; a pop from empty is never honoured, even if a push
  // arrives alongside it.
  assign pop     = read_i && !empty_o;
  assign push    = write_i && (!full_o || pop);
  assign error_o = (write_i && full_o && !read_i) || (read_i && empty_o);

  assign data_o  = empty_o ? '0 : mem[rd_ptr[IW-1:0]];

  // Storage array: written on accepted pushes, deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= data_i;
  end

  // Pointer advance; natural modulo-2*SLOTS wrap through the extra bit.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_flit_fifo.sv
// Scoreboard bench for flit_fifo: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares whenever a pop is accepted.
module tb_flit_fifo;
  localparam int SLOTS = 8;
  localparam int WIDTH = 34;

  logic             clk = 1'b0;
  logic             arst = 1'b1;
  logic             write_i = 1'b0;
  logic             read_i = 1'b0;
  logic [WIDTH-1:0] data_i = '0;
  logic [WIDTH-1:0] data_o;
  logic             error_o, full_o, empty_o;

  int n_cmp = 0;
  int n_bad = 0;
  int occ = 0;
  logic [WIDTH-1:0] exp_q [$];

  flit_fifo #(.SLOTS(SLOTS), .WIDTH(WIDTH)) dut (
    .clk(clk), .arst(arst), .write_i(write_i), .read_i(read_i),
    .data_i(data_i), .data_o(data_o), .error_o(error_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] mk(input int i);
    logic [31:0] lo;
    lo = 32'hC0DE_0000 + 32'(i) * 32'h0001_1111;
    return {2'(i), lo};
  endfunction

  // Monitor: an accepted pop must present the oldest outstanding word.
  always @(negedge clk) begin
    if (!arst && read_i && !empty_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got %h want none", data_o);
      end else begin
        chk("pop_data", 64'(data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  // One clock of stimulus: drive after the edge, model acceptance, check
  // flags at mid-cycle, then advance the occupancy model.
  task automatic cyc(input logic w, input logic r, input logic [WIDTH-1:0] d);
    logic exp_err, push_ok, pop_ok;
    @(posedge clk); #1;
    write_i = w; read_i = r; data_i = d;
    exp_err = (w && occ == SLOTS && !r) || (r && occ == 0);
    pop_ok  = r && occ > 0;
    push_ok = w && (occ < SLOTS || pop_ok);
    if (push_ok) exp_q.push_back(d);
    @(negedge clk);
    chk("error", 64'(error_o), 64'(exp_err));
    chk("full",  64'(full_o),  64'(occ == SLOTS));
    chk("empty", 64'(empty_o), 64'(occ == 0));
    if (occ == 0) chk("data_empty", 64'(data_o), 64'd0);
    occ = occ + int'(push_ok) - int'(pop_ok);
  endtask

  initial begin
    // Reset held for 10 cycles
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_full",  64'(full_o),  64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_data",  64'(data_o),  64'd0);
    arst = 1'b0;

    // Fill
    for (int i = 0; i < SLOTS; i++) cyc(1'b1, 1'b0, mk(i));
    cyc(1'b0, 1'b0, '0);
    chk("fill_head", 64'(data_o), 64'(mk(0)));
    // Overflow, dropped
    cyc(1'b1, 1'b0, 34'h3_DEAD_BEEF);
    // Drain plus one extra pop from empty
    for (int i = 0; i < SLOTS; i++) cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);

    // Push+pop on empty, then streaming push+pop at occupancy one
    cyc(1'b1, 1'b1, mk(100));
    cyc(1'b0, 1'b0, '0);
    chk("ep_head", 64'(data_o), 64'(mk(100)));
    for (int i = 0; i < 50; i++) cyc(1'b1, 1'b1, mk(200 + i));
    cyc(1'b0, 1'b1, '0);

    // Full push+pop keeps FIFO full and order intact
    for (int i = 0; i < SLOTS; i++) cyc(1'b1, 1'b0, mk(300 + i));
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, mk(400 + i));
    for (int i = 0; i < SLOTS; i++) cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);
    chk("q_drained", 64'(exp_q.size()), 64'd0);

    // Mid-operation asynchronous reset: flags clear without a clock edge
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, mk(500 + i));
    @(posedge clk); #1;
    write_i = 1'b0; read_i = 1'b0;
    #2 arst = 1'b1;
    #1;
    chk("arst_empty", 64'(empty_o), 64'd1);
    chk("arst_full",  64'(full_o),  64'd0);
    chk("arst_data",  64'(data_o),  64'd0);
    exp_q.delete();
    occ = 0;
    @(negedge clk); arst = 1'b0;
    cyc(1'b1, 1'b0, mk(600));
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
